// File: rtl/weight_buffer_loader_if.sv
// Weight-load bus: controller enables, DMA beat stream in, weight rows out to the array.
// Pure signal bundle. No latency. tready/tvalid handshake on the DMA side; rows are pushed with no backpressure.
interface weight_buffer_loader_if #(
    parameter int ARRAY_ROWS = 12,
    parameter int ARRAY_COLS = 16,
    parameter int DATA_W     = 8,
    parameter int DMA_W      = 64
);
    localparam int ROW_W = ARRAY_COLS * DATA_W;
    localparam int IDX_W = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;

    logic             ctrl_weight_dma_req;
    logic             ctrl_weight_load_en;
    logic [DMA_W-1:0] s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [ROW_W-1:0] w_row_data;
    logic             w_row_valid;
    logic [IDX_W-1:0] w_row_idx;
    logic             buf_full;
    logic             w_load_done;
    logic             err_underrun;

    modport master (
        output ctrl_weight_dma_req, ctrl_weight_load_en, s_axis_tdata, s_axis_tvalid,
        input  s_axis_tready, w_row_data, w_row_valid, w_row_idx, buf_full, w_load_done, err_underrun
    );

    modport slave (
        input  ctrl_weight_dma_req, ctrl_weight_load_en, s_axis_tdata, s_axis_tvalid,
        output s_axis_tready, w_row_data, w_row_valid, w_row_idx, buf_full, w_load_done, err_underrun
    );
endinterface

// File: rtl/weight_buffer_loader.sv
// Buffers DMA weight beats into rows, then replays rows top-down into the array's shift chain.
// Rows appear 1 cycle after a load_en sample; tready is combinational and drops once the buffer holds all beats.
module weight_buffer_loader #(
    parameter int ARRAY_ROWS = 12,
    parameter int ARRAY_COLS = 16,
    parameter int DATA_W     = 8,
    parameter int DMA_W      = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    weight_buffer_loader_if.slave bus
);
    localparam int ROW_W = ARRAY_COLS * DATA_W;
    localparam int BPR   = ROW_W / DMA_W;
    localparam int IDX_W = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;
    localparam int SL_W  = (BPR > 1) ? $clog2(BPR) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] READY = 2'd2;
    localparam logic [1:0] LOAD  = 2'd3;

    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ARRAY_ROWS - 1);
    localparam logic [SL_W-1:0]  LAST_SL  = SL_W'(BPR - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] wr_row_q, wr_row_d;
    logic [SL_W-1:0]  wr_sl_q, wr_sl_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] row_idx_q, row_idx_d;
    logic [ROW_W-1:0] row_dat_q, row_dat_d;
    logic             row_vld_q, row_vld_d;
    logic             buf_full_q, buf_full_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic [ROW_W-1:0] mem [ARRAY_ROWS];

    logic             beat_acc;
    logic             present;
    logic [IDX_W-1:0] beat_row;
    logic [SL_W-1:0]  beat_sl;
    logic [IDX_W-1:0] pres_idx;

    // IDLE accepts too, so a back-to-back controller schedule of TOTAL dma_req cycles fills completely.
    assign bus.s_axis_tready = bus.ctrl_weight_dma_req && ((state_q == IDLE) || (state_q == FILL));
    assign beat_acc = bus.s_axis_tready && bus.s_axis_tvalid;
    assign beat_row = (state_q == IDLE) ? '0 : wr_row_q;
    assign beat_sl  = (state_q == IDLE) ? '0 : wr_sl_q;
    assign pres_idx = (state_q == READY) ? LAST_ROW : rd_idx_q;
    assign present  = bus.ctrl_weight_load_en && ((state_q == READY) || (state_q == LOAD));

    always_comb begin
        state_d    = state_q;
        wr_row_d   = wr_row_q;
        wr_sl_d    = wr_sl_q;
        rd_idx_d   = rd_idx_q;
        row_idx_d  = row_idx_q;
        row_dat_d  = row_dat_q;
        row_vld_d  = 1'b0;
        buf_full_d = buf_full_q;
        err_d      = err_q;
        done_d     = row_vld_q && (row_idx_q == '0);
        if (done_d) buf_full_d = 1'b0;

        case (state_q)
            IDLE: if (bus.ctrl_weight_dma_req) begin
                state_d    = FILL;
                err_d      = 1'b0;
                buf_full_d = 1'b0;
                wr_row_d   = '0;
                wr_sl_d    = '0;
            end
            FILL: if (bus.ctrl_weight_load_en) err_d = 1'b1;
            default: ;
        endcase

        if (beat_acc) begin
            if (beat_sl == LAST_SL) begin
                wr_sl_d  = '0;
                wr_row_d = beat_row + 1'b1;
                if (beat_row == LAST_ROW) begin
                    state_d    = READY;
                    buf_full_d = 1'b1;
                end
            end else begin
                wr_sl_d  = beat_sl + 1'b1;
                wr_row_d = beat_row;
            end
        end

        if (present) begin
            row_vld_d = 1'b1;
            row_idx_d = pres_idx;
            row_dat_d = mem[pres_idx];
            if (pres_idx == '0) begin
                state_d = IDLE;
            end else begin
                state_d  = LOAD;
                rd_idx_d = pres_idx - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat_acc) begin
            for (int s = 0; s < BPR; s++) begin
                if (beat_sl == SL_W'(s)) mem[beat_row][s*DMA_W +: DMA_W] <= bus.s_axis_tdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_row_q   <= '0;
            wr_sl_q    <= '0;
            rd_idx_q   <= '0;
            row_idx_q  <= '0;
            row_dat_q  <= '0;
            row_vld_q  <= 1'b0;
            buf_full_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_row_q   <= wr_row_d;
            wr_sl_q    <= wr_sl_d;
            rd_idx_q   <= rd_idx_d;
            row_idx_q  <= row_idx_d;
            row_dat_q  <= row_dat_d;
            row_vld_q  <= row_vld_d;
            buf_full_q <= buf_full_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign bus.w_row_data   = row_dat_q;
    assign bus.w_row_valid  = row_vld_q;
    assign bus.w_row_idx    = row_idx_q;
    assign bus.buf_full     = buf_full_q;
    assign bus.w_load_done  = done_q;
    assign bus.err_underrun = err_q;
endmodule

// File: tb/tb_weight_buffer_loader.sv
// Bench for weight_buffer_loader: scenario table plus randomized runs against a transaction-level model.
module tb_weight_buffer_loader;
    localparam int ROWS  = 12;
    localparam int COLS  = 16;
    localparam int DW    = 8;
    localparam int DMA   = 64;
    localparam int ROW_W = COLS * DW;
    localparam int BPR   = ROW_W / DMA;
    localparam int TOTAL = ROWS * BPR;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    weight_buffer_loader_if #(.ARRAY_ROWS(ROWS), .ARRAY_COLS(COLS), .DATA_W(DW), .DMA_W(DMA)) bus ();

    weight_buffer_loader #(.ARRAY_ROWS(ROWS), .ARRAY_COLS(COLS), .DATA_W(DW), .DMA_W(DMA)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int dma_cyc;  int st_at;  int st_len; int uf_at;
        int ld1;      int gap;    int ld2;
        int e_beats;  int e_rows; int e_done; int e_err; int e_rdy;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: source beats, buffered beats, and counts of beats taken / rows handed out.
    logic [DMA-1:0]   src  [TOTAL];
    logic [DMA-1:0]   mbuf [TOTAL];
    int               sent, m_beats, m_rows;
    bit               m_started, m_pend_done;
    logic             m_vld, m_done, m_full, m_err;
    logic [3:0]       m_idx;
    logic [ROW_W-1:0] m_dat;
    int               obs_beats, obs_rows, obs_done, obs_rdy;

    task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sent = 0; m_beats = 0; m_rows = 0; m_started = 0; m_pend_done = 0;
        m_vld = 0; m_done = 0; m_full = 0; m_err = 0; m_idx = '0; m_dat = '0;
    endtask

    task automatic new_src(input bit rnd);
        for (int k = 0; k < TOTAL; k++) src[k] = rnd ? {$urandom, $urandom} : DMA'(k % 256);
        sent = 0;
    endtask

    // Called at a negedge: check registered outputs, drive inputs, check tready, advance model one edge.
    task automatic step(input bit dma, input bit ld, input bit tv);
        bit exp_rdy;
        bit nv;
        int r;
        chk("w_row_valid", bus.w_row_valid, m_vld);
        chk("w_row_idx", bus.w_row_idx, m_idx);
        chk("w_row_data", bus.w_row_data, m_dat);
        chk("w_load_done", bus.w_load_done, m_done);
        chk("buf_full", bus.buf_full, m_full);
        chk("err_underrun", bus.err_underrun, m_err);
        if (bus.w_row_valid) obs_rows++;
        if (bus.w_load_done) obs_done++;

        bus.ctrl_weight_dma_req = dma;
        bus.ctrl_weight_load_en = ld;
        bus.s_axis_tvalid       = tv;
        bus.s_axis_tdata        = (sent < TOTAL) ? src[sent] : '0;
        #1;
        exp_rdy = dma && (!m_started || m_beats < TOTAL);
        chk("s_axis_tready", bus.s_axis_tready, exp_rdy);
        if (bus.s_axis_tready) obs_rdy++;
        if (bus.s_axis_tready && tv) obs_beats++;

        nv = 0;
        m_done = m_pend_done;
        m_pend_done = 0;
        if (m_done) m_full = 0;
        if (!m_started) begin
            if (dma) begin m_started = 1; m_beats = 0; m_err = 0; m_full = 0; end
        end else if (m_beats < TOTAL) begin
            if (ld) m_err = 1;
        end else if (ld) begin
            r = ROWS - 1 - m_rows;
            nv = 1;
            m_idx = 4'(r);
            for (int s = 0; s < BPR; s++) m_dat[s*DMA +: DMA] = mbuf[r*BPR + s];
            m_rows++;
            if (r == 0) begin m_pend_done = 1; m_started = 0; m_rows = 0; m_beats = 0; end
        end
        if (tv && exp_rdy) begin
            mbuf[m_beats] = src[sent];
            sent++;
            m_beats++;
            if (m_beats == TOTAL) m_full = 1;
        end
        m_vld = nv;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        obs_beats = 0; obs_rows = 0; obs_done = 0; obs_rdy = 0;
        new_src(0);
        for (int c = 0; c < v.dma_cyc; c++)
            step(1'b1, c == v.uf_at, !(c >= v.st_at && c < v.st_at + v.st_len));
        chk($sformatf("v%0d err_after_fill", id), bus.err_underrun, v.e_err[0]);
        for (int c = 0; c < v.ld1; c++) step(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < v.gap; c++) step(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < v.ld2; c++) step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk($sformatf("v%0d beats", id), obs_beats, v.e_beats);
        chk($sformatf("v%0d rows", id), obs_rows, v.e_rows);
        chk($sformatf("v%0d done_pulses", id), obs_done, v.e_done);
        chk($sformatf("v%0d tready_cycles", id), obs_rdy, v.e_rdy);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " tready"}, bus.s_axis_tready, 1'b0);
        chk({tag, " valid"}, bus.w_row_valid, 1'b0);
        chk({tag, " data"}, bus.w_row_data, '0);
        chk({tag, " idx"}, bus.w_row_idx, '0);
        chk({tag, " full"}, bus.buf_full, 1'b0);
        chk({tag, " done"}, bus.w_load_done, 1'b0);
        chk({tag, " err"}, bus.err_underrun, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int guard;
        vecs[0] = '{24, -1, 0, -1, 12, 0, 0, 24, 12, 1, 0, 24};  // nominal
        vecs[1] = '{29,  8, 5, -1, 12, 0, 0, 24, 12, 1, 0, 29};  // DMA stall
        vecs[2] = '{24, -1, 0, -1,  4, 3, 9, 24, 12, 1, 0, 24};  // load gap + extra load_en in IDLE
        vecs[3] = '{24, -1, 0, 10, 12, 0, 0, 24, 12, 1, 1, 24};  // underrun
        vecs[4] = '{30, -1, 0, -1, 12, 0, 0, 24, 12, 1, 0, 24};  // overflow guard, dma_req in READY

        rst_n = 1'b0;
        bus.ctrl_weight_dma_req = 1'b0;
        bus.ctrl_weight_load_en = 1'b0;
        bus.s_axis_tvalid       = 1'b0;
        bus.s_axis_tdata        = '0;
        model_reset();
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Reset while rows are being shifted out, then a clean full run.
        new_src(0);
        for (int c = 0; c < TOTAL; c++) step(1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) step(1'b0, 1'b1, 1'b0);
        chk("pre_reset valid", bus.w_row_valid, 1'b1);
        chk("pre_reset idx", bus.w_row_idx, 4'd7);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("mid_load_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0], 5);

        // Randomized fills and loads with random stalls, gaps, dma_req drops and stray load_en.
        for (int it = 0; it < 8; it++) begin
            new_src(1);
            guard = 0;
            while (!(m_started && m_beats == TOTAL) && guard < 300) begin
                step(($urandom_range(0, 5) != 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
                guard++;
            end
            if (guard >= 300) begin
                n_tests++; n_fail++;
                $display("FAIL rand%0d fill_timeout: beats %0d required %0d", it, m_beats, TOTAL);
            end
            guard = 0;
            while (m_started && guard < 300) begin
                step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0), 1'b0);
                guard++;
            end
            if (guard >= 300) begin
                n_tests++; n_fail++;
                $display("FAIL rand%0d load_timeout: rows %0d required %0d", it, m_rows, ROWS);
            end
            repeat (3) step(1'b0, $urandom_range(0, 1) == 1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
